// File: rtl/apb_ral_v2_pkg.sv
// Shared types and register-map constants for the APB RAL slave.
package apb_ral_v2_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef enum logic [1:0] {DEC_RAM, DEC_REG, DEC_ERR} dec_t;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_INT_STAT = 2'd2;
    localparam logic [1:0] REG_INT_EN   = 2'd3;

endpackage

// File: rtl/apb_ral_apb_slave_v2_if.sv
// APB bus bundle between a master and the RAL slave.
interface apb_ral_apb_slave_v2_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BYTES = DATA_W / 8;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [BYTES-1:0]  pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_ral_v2_regfile.sv
// CTRL / STATUS / INT_STAT / INT_EN storage with byte-strobe merge,
// write-one-to-clear interrupt status and a registered irq output.
module apb_ral_v2_regfile
    import apb_ral_v2_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [1:0]            wr_idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [1:0]            rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [DATA_W-1:0]     sta_i,
    input  logic [DATA_W-1:0]     irq_evt_i,
    output logic [DATA_W-1:0]     ctrl_o,
    output logic                  irq_o
);
    localparam int BYTES = int'(DATA_W / 8);

    logic [DATA_W-1:0] ctrl_q, int_stat, int_en, mask, clr;

    // Expand byte strobes to a bit mask; W1C clear only hits enabled lanes.
    always_comb begin
        mask = '0;
        for (int b = 0; b < BYTES; b++) mask[b*8 +: 8] = {8{wstrb[b]}};
        clr = (wr_en && wr_idx == REG_INT_STAT) ? (wdata & mask) : '0;
    end

    // Register updates; a set pulse overrides a clear on the same bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            int_en   <= '0;
            int_stat <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_en && wr_idx == REG_CTRL)   ctrl_q <= (ctrl_q & ~mask) | (wdata & mask);
            if (wr_en && wr_idx == REG_INT_EN) int_en <= (int_en & ~mask) | (wdata & mask);
            int_stat <= (int_stat & ~clr) | irq_evt_i;
            irq_o    <= |(int_stat & int_en);
        end
    end

    // Read mux; STATUS passes sta_i straight through so the caller samples it.
    always_comb begin
        case (rd_idx)
            REG_CTRL:     rd_data = ctrl_q;
            REG_STATUS:   rd_data = sta_i;
            REG_INT_STAT: rd_data = int_stat;
            default:      rd_data = int_en;
        endcase
    end

    assign ctrl_o = ctrl_q;
endmodule

// File: rtl/apb_ral_apb_slave_v2.sv
// APB slave: word RAM plus a small register block, with programmable wait
// states, byte strobes and decode errors. Holds FSM, decode and RAM.
module apb_ral_apb_slave_v2
    import apb_ral_v2_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RAM_DEPTH   = 1024,
    parameter int unsigned REG_BASE    = 'h1000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_ral_apb_slave_v2_if.slave bus,
    input  logic [DATA_W-1:0]    sta_i,
    input  logic [DATA_W-1:0]    irq_evt_i,
    output logic [DATA_W-1:0]    ctrl_o,
    output logic                 irq_o
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int          NB    = int'(BYTES);
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_W:0]   RAM_END = (ADDR_W+1)'(RAM_DEPTH * BYTES);
    localparam logic [ADDR_W:0]   REG_LO  = (ADDR_W+1)'(REG_BASE);
    localparam logic [ADDR_W:0]   REG_HI  = (ADDR_W+1)'(REG_BASE + 4 * BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(BYTES - 1);

    // Contents are not touched by reset; power-up value comes from the device.
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    state_t            state_q, phase;
    dec_t              dec, a_dec;
    logic [ADDR_W:0]   pa;
    logic [1:0]        ridx, a_ridx;
    logic [IDX_W-1:0]  widx, a_widx;
    logic [DATA_W-1:0] reg_rd, rd_val, rd_hold;
    logic [3:0]        cnt;
    logic              a_write, wr_fire, ram_we, reg_we;

    // Address decode of the current bus address (used in the SETUP cycle).
    always_comb begin
        pa   = {1'b0, bus.paddr};
        ridx = 2'((pa - REG_LO) >> OFF);
        widx = IDX_W'(bus.paddr >> OFF);
        dec  = DEC_ERR;
        if ((bus.paddr & ALIGN_M) != '0)
            dec = DEC_ERR;
        else if (pa < RAM_END)
            dec = DEC_RAM;
        else if (pa >= REG_LO && pa < REG_HI && !(bus.pwrite && ridx == REG_STATUS))
            dec = DEC_REG;
        rd_val = '0;
        case (dec)
            DEC_RAM: rd_val = mem[widx];
            DEC_REG: rd_val = reg_rd;
            default: rd_val = '0;
        endcase
    end

    // The SETUP state is the bus setup phase seen while idle; it lasts one cycle.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && bus.psel && !bus.penable) phase = SETUP;
    end

    // Transfer FSM with registered pready/pslverr/prdata.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
            cnt         <= '0;
            a_write     <= 1'b0;
            a_dec       <= DEC_ERR;
            a_widx      <= '0;
            a_ridx      <= '0;
            rd_hold     <= '0;
        end else begin
            case (phase)
                SETUP: begin
                    state_q <= ACCESS;
                    a_write <= bus.pwrite;
                    a_dec   <= dec;
                    a_widx  <= widx;
                    a_ridx  <= ridx;
                    cnt     <= 4'(WAIT_STATES);
                    rd_hold <= rd_val;
                    if (WAIT_STATES == 0) begin
                        bus.pready  <= 1'b1;
                        bus.pslverr <= (dec == DEC_ERR);
                        if (!bus.pwrite || dec == DEC_ERR) bus.prdata <= rd_val;
                    end
                end
                ACCESS: begin
                    // Completion, or a master that gave up early: either way back to IDLE.
                    if (!bus.psel || !bus.penable || bus.pready) begin
                        state_q     <= IDLE;
                        bus.pready  <= 1'b0;
                        bus.pslverr <= 1'b0;
                    end else begin
                        if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            bus.pready  <= 1'b1;
                            bus.pslverr <= (a_dec == DEC_ERR);
                            if (!a_write || a_dec == DEC_ERR) bus.prdata <= rd_hold;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_fire = presetn && state_q == ACCESS && bus.pready && bus.psel && bus.penable && a_write;
    assign ram_we  = wr_fire && a_dec == DEC_RAM;
    assign reg_we  = wr_fire && a_dec == DEC_REG;

    // RAM write with per-byte strobes on the completion edge.
    always_ff @(posedge pclk) begin
        if (ram_we)
            for (int b = 0; b < NB; b++)
                if (bus.pstrb[b]) mem[a_widx][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
    end

    apb_ral_v2_regfile #(.DATA_W(DATA_W)) u_regs (
        .clk       (pclk),
        .rst_n     (presetn),
        .wr_en     (reg_we),
        .wr_idx    (a_ridx),
        .wdata     (bus.pwdata),
        .wstrb     (bus.pstrb),
        .rd_idx    (ridx),
        .rd_data   (reg_rd),
        .sta_i     (sta_i),
        .irq_evt_i (irq_evt_i),
        .ctrl_o    (ctrl_o),
        .irq_o     (irq_o)
    );
endmodule

// File: tb/tb_apb_ral_apb_slave_v2.sv
// Bench: two slaves (0 and 3 wait states) on a shared stimulus bus, checked
// against an address-map level model of RAM, registers and interrupts.
module tb_apb_ral_apb_slave_v2;
    localparam int AW = 16, DW = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          psel = 0, penable = 0, pwrite = 0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0, sta = '0, evt = '0, rdv;
    logic [3:0]    pstrb = '0;
    int            sel = 0;
    logic [DW-1:0] ctrl0, ctrl1, prdata_m;
    logic          irq0, irq1, pready_m, pslverr_m;

    apb_ral_apb_slave_v2_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    apb_ral_apb_slave_v2_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus0.psel = psel && sel == 0;
    assign bus1.psel = psel && sel == 1;
    assign bus0.penable = penable;  assign bus1.penable = penable;
    assign bus0.pwrite  = pwrite;   assign bus1.pwrite  = pwrite;
    assign bus0.paddr   = paddr;    assign bus1.paddr   = paddr;
    assign bus0.pwdata  = pwdata;   assign bus1.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;    assign bus1.pstrb   = pstrb;
    assign pready_m  = (sel != 0) ? bus1.pready  : bus0.pready;
    assign pslverr_m = (sel != 0) ? bus1.pslverr : bus0.pslverr;
    assign prdata_m  = (sel != 0) ? bus1.prdata  : bus0.prdata;

    apb_ral_apb_slave_v2 #(.WAIT_STATES(0)) dut0 (
        .pclk(clk), .presetn(rst_n), .bus(bus0.slave),
        .sta_i(sta), .irq_evt_i(evt), .ctrl_o(ctrl0), .irq_o(irq0));
    apb_ral_apb_slave_v2 #(.WAIT_STATES(3)) dut1 (
        .pclk(clk), .presetn(rst_n), .bus(bus1.slave),
        .sta_i(sta), .irq_evt_i(evt), .ctrl_o(ctrl1), .irq_o(irq1));

    // Reference model: what each slave's address map should contain.
    logic [31:0] m_ram [2][64];
    logic [31:0] m_ctrl [2], m_en [2], m_stat [2];

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // RAM at 0x0000-0x0FFF, registers at 0x1000-0x100F, STATUS read-only.
    function automatic logic exp_err(input logic wr, input logic [15:0] a);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < 16'h1000) return 1'b0;
        if (a < 16'h1010) return wr && (a[3:2] == 2'd1);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [15:0] a);
        if (a < 16'h1000) return m_ram[d][a[7:2]];
        case (a[3:2])
            2'd0:    return m_ctrl[d];
            2'd1:    return sta;
            2'd2:    return m_stat[d];
            default: return m_en[d];
        endcase
    endfunction

    task automatic m_write(input int d, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] m = smask(st);
        if (a < 16'h1000) m_ram[d][a[7:2]] = (m_ram[d][a[7:2]] & ~m) | (wd & m);
        else case (a[3:2])
            2'd0:    m_ctrl[d] = (m_ctrl[d] & ~m) | (wd & m);
            2'd2:    m_stat[d] = m_stat[d] & ~(wd & m);
            2'd3:    m_en[d]   = (m_en[d] & ~m) | (wd & m);
            default: ;
        endcase
    endtask

    // One APB transfer; ev is presented so it lands on the completion edge.
    task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] ev,
                        output logic [31:0] rd, output logic er, output int waits);
        sel = d; psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        waits = 0; rd = '0; er = 1'b0;
        @(posedge clk); #1 penable = 1;
        forever begin
            @(negedge clk);
            if (pready_m) begin rd = prdata_m; er = pslverr_m; break; end
            waits++;
            if (waits > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL pready_timeout: no pready after %0d cycles, addr %h", waits, a);
                break;
            end
            @(posedge clk); #1;
        end
        evt = ev;
        @(posedge clk); #1 psel = 0; penable = 0; evt = '0;
    endtask

    task automatic run(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] ev, output logic [31:0] rd);
        logic e_err, er;
        logic [31:0] e_rd;
        int w;
        e_err = exp_err(wr, a);
        e_rd  = e_err ? 32'h0 : m_read(d, a);
        xfer(d, wr, a, wd, st, ev, rd, er, w);
        chk($sformatf("pslverr d%0d a%h", d, a), 32'(er), 32'(e_err));
        if (!wr || e_err) chk($sformatf("prdata d%0d a%h", d, a), rd, e_rd);
        chk($sformatf("waits d%0d", d), 32'(w), (d == 0) ? 32'd0 : 32'd3);
        if (wr && !e_err) m_write(d, a, wd, st);
        for (int k = 0; k < 2; k++) m_stat[k] = m_stat[k] | ev;
        chk($sformatf("ctrl_o d%0d", d), (d == 0) ? ctrl0 : ctrl1, m_ctrl[d]);
    endtask

    task automatic chk_irq(input string tag);
        chk({tag, "_irq0"}, 32'(irq0), 32'(|(m_stat[0] & m_en[0])));
        chk({tag, "_irq1"}, 32'(irq1), 32'(|(m_stat[1] & m_en[1])));
    endtask

    task automatic pulse(input logic [31:0] v);
        evt = v;
        @(posedge clk); #1 evt = '0;
        for (int k = 0; k < 2; k++) m_stat[k] = m_stat[k] | v;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin m_ctrl[k] = '0; m_en[k] = '0; m_stat[k] = '0; end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) for (int i = 0; i < 64; i++) m_ram[k][i] = '0;
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        chk("rst_pready0",  32'(bus0.pready),  0);
        chk("rst_pslverr0", 32'(bus0.pslverr), 0);
        chk("rst_prdata0",  bus0.prdata, 0);
        chk("rst_pready1",  32'(bus1.pready),  0);
        chk("rst_prdata1",  bus1.prdata, 0);
        chk("rst_ctrl0", ctrl0, 0);
        chk("rst_ctrl1", ctrl1, 0);
        chk_irq("rst");

        // Fill a RAM window on both slaves so later reads have known data
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) run(d, 1, 16'(w * 4), $urandom, 4'hF, 0, rdv);

        // Zero-wait write/read
        run(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rdv);
        run(0, 0, 16'h0010, 0, 4'h0, 0, rdv);
        chk("ws0_read", rdv, 32'hDEADBEEF);

        // Three wait states, CTRL visible right after completion
        run(1, 1, 16'h1000, 32'h5, 4'hF, 0, rdv);
        chk("ws3_ctrl", ctrl1, 32'h5);

        // Byte strobe on CTRL
        run(0, 1, 16'h1000, 32'h0, 4'hF, 0, rdv);
        run(0, 1, 16'h1000, 32'hFFFFFFFF, 4'b0010, 0, rdv);
        chk("ctrl_strb", ctrl0, 32'h0000FF00);

        // Decode errors leave state alone
        run(0, 0, 16'h0802, 0, 4'h0, 0, rdv);
        run(0, 0, 16'h1010, 0, 4'h0, 0, rdv);
        run(0, 1, 16'h1004, 32'hFFFFFFFF, 4'hF, 0, rdv);
        run(0, 1, 16'h0012, 32'h11111111, 4'hF, 0, rdv);
        run(0, 1, 16'hFFFC, 32'h22222222, 4'hF, 0, rdv);
        run(0, 0, 16'h0010, 0, 4'h0, 0, rdv);
        chk("err_ram_kept", rdv, 32'hDEADBEEF);
        chk("err_ctrl_kept", ctrl0, 32'h0000FF00);

        // Interrupts: enable, set, W1C racing a set, plain W1C
        run(0, 1, 16'h100C, 32'h1, 4'hF, 0, rdv);
        pulse(32'h1);
        @(posedge clk); #1;
        chk_irq("irq_set");
        run(0, 1, 16'h1008, 32'h1, 4'hF, 32'h1, rdv);
        run(0, 0, 16'h1008, 0, 4'h0, 0, rdv);
        chk("w1c_set_wins", rdv, 32'h1);
        chk_irq("irq_still");
        run(0, 1, 16'h1008, 32'h1, 4'hF, 0, rdv);
        chk("irq_lag", 32'(irq0), 32'(|(m_stat[0] == 32'h0 ? 32'h1 : 32'h0)));
        @(posedge clk); #1;
        chk_irq("irq_clr");

        // Reset in the middle of a waited RAM write
        sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 16'h0020; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1;
        @(negedge clk);
        chk("abort_wait_pready", 32'(bus1.pready), 0);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        chk("abort_rst_pready", 32'(bus1.pready), 0);
        rst_n = 1; psel = 0; penable = 0;
        model_reset();
        @(posedge clk); #1;
        chk("abort_ctrl1", ctrl1, 0);
        chk_irq("abort");
        run(1, 0, 16'h0020, 0, 4'h0, 0, rdv);

        // Randomised traffic against the model
        for (int i = 0; i < 120; i++) begin
            int d, kind;
            logic wr;
            logic [15:0] a;
            d = int'($urandom_range(1, 0));
            wr = 1'($urandom_range(1, 0));
            kind = int'($urandom_range(6, 0));
            case (kind)
                0, 1, 2: a = 16'($urandom_range(63, 0) * 4);
                3, 4:    a = 16'h1000 + 16'($urandom_range(3, 0) * 4);
                5:       a = 16'($urandom_range(63, 0) * 4 + $urandom_range(3, 1));
                default: a = 16'h1010 + 16'($urandom_range(1000, 0) * 4);
            endcase
            sta = $urandom;
            if ($urandom_range(3, 0) == 0) pulse($urandom & $urandom);
            run(d, wr, a, $urandom, 4'($urandom_range(15, 0)), 0, rdv);
            @(posedge clk); #1;
            chk_irq("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
